// File: rtl/secuenciador_bus_rtc_pkg.sv
// Shared types and constants for the RTC multiplexed bus sequencer.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DIR_ACT  = 3'd1,
        DIR_FIN  = 3'd2,
        DATO_ACT = 3'd3,
        DATO_FIN = 3'd4,
        RECUPERA = 3'd5
    } estado_t;

    // Level of every active-low strobe when the bus is released.
    localparam logic NIVEL_REPOSO = 1'b1;

    localparam int T_FASE_DEF = 4;

    // Phase counter width; wide enough for the largest legal phase length (255).
    localparam int ANCHO_FASE = 8;

endpackage

// File: rtl/secuenciador_bus_rtc_temporizador_fase.sv
// Phase counter: counts 0..ultimo, pulses fin on the last count, clears on request.
module temporizador_fase #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             borrar,
    input  logic [ANCHO-1:0] ultimo,
    output logic             fin
);

    logic [ANCHO-1:0] cuenta;

    assign fin = (cuenta == ultimo);

    // Count up, wrapping at the terminal value or restarting when the phase changes.
    always_ff @(posedge clk) begin
        if (rst || borrar || fin) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + ANCHO'(1);
        end
    end

endmodule

// File: rtl/secuenciador_bus_rtc.sv
// Runs one multiplexed address/data bus cycle (write or read) to the external RTC chip.
//
//   state    | meaning
//   IDLE     | bus released, waiting for a start pulse
//   DIR_ACT  | address driven, ad_n and wr_n low
//   DIR_FIN  | address held, wr_n high (chip latches address on its rising edge)
//   DATO_ACT | data phase: wr_n low (write) or rd_n low with bus released (read)
//   DATO_FIN | strobes high, cs_n still low; write data held on the bus
//   RECUPERA | cs_n high, bus released before returning to IDLE
module secuenciador_bus_rtc
    import rtc_bus_pkg::*;
#(
    parameter int T_FASE = T_FASE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] direccion,
    input  logic [7:0] dato_escritura,
    input  logic       inicio_escritura,
    input  logic       inicio_lectura,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_leido,
    output logic       ocupado,
    output logic       listo
);

    localparam logic [ANCHO_FASE-1:0] ULTIMO = ANCHO_FASE'(T_FASE - 1);

    estado_t    estado, estado_sig;
    logic       fin_fase, cambio, arranque;
    logic [7:0] dir_q, dato_q;
    logic       lectura_q;
    logic [7:0] dir_act;
    logic       lectura_act;
    logic [7:0] ad_out_d;
    logic       ad_oe_d, cs_n_d, ad_n_d, wr_n_d, rd_n_d;

    // A start is only honoured in IDLE; write has priority over read.
    assign arranque    = (estado == IDLE) && (inicio_escritura || inicio_lectura);
    assign cambio      = (estado_sig != estado);
    // On the start edge the latches are not yet loaded, so decode straight from the inputs.
    assign dir_act     = arranque ? direccion : dir_q;
    assign lectura_act = arranque ? ~inicio_escritura : lectura_q;

    temporizador_fase #(
        .ANCHO (ANCHO_FASE)
    ) u_fase (
        .clk    (clk),
        .rst    (rst),
        .borrar (cambio),
        .ultimo (ULTIMO),
        .fin    (fin_fase)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state: every non-idle phase advances when the phase counter terminates.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:     if (arranque) estado_sig = DIR_ACT;
            DIR_ACT:  if (fin_fase) estado_sig = DIR_FIN;
            DIR_FIN:  if (fin_fase) estado_sig = DATO_ACT;
            DATO_ACT: if (fin_fase) estado_sig = DATO_FIN;
            DATO_FIN: if (fin_fase) estado_sig = RECUPERA;
            RECUPERA: if (fin_fase) estado_sig = IDLE;
            default:  estado_sig = IDLE;
        endcase
    end

    // Bus levels for the state about to be entered; registered below so the pins never glitch.
    always_comb begin
        ad_out_d = 8'h00;
        ad_oe_d  = 1'b0;
        cs_n_d   = NIVEL_REPOSO;
        ad_n_d   = NIVEL_REPOSO;
        wr_n_d   = NIVEL_REPOSO;
        rd_n_d   = NIVEL_REPOSO;
        case (estado_sig)
            DIR_ACT: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = dir_act;
            end
            DIR_FIN: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = dir_act;
            end
            DATO_ACT: begin
                cs_n_d = 1'b0;
                if (lectura_act) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = dato_q;
                end
            end
            DATO_FIN: begin
                cs_n_d = 1'b0;
                if (!lectura_act) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = dato_q;
                end
            end
            default: ;
        endcase
    end

    // Capture the operation parameters when a cycle is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q     <= 8'h00;
            dato_q    <= 8'h00;
            lectura_q <= 1'b0;
        end else if (arranque) begin
            dir_q     <= direccion;
            dato_q    <= dato_escritura;
            lectura_q <= ~inicio_escritura;
        end
    end

    // Output registers, status flags and read-data capture at the end of the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_out     <= 8'h00;
            ad_oe      <= 1'b0;
            cs_n       <= NIVEL_REPOSO;
            ad_n       <= NIVEL_REPOSO;
            wr_n       <= NIVEL_REPOSO;
            rd_n       <= NIVEL_REPOSO;
            dato_leido <= 8'h00;
            ocupado    <= 1'b0;
            listo      <= 1'b0;
        end else begin
            ad_out  <= ad_out_d;
            ad_oe   <= ad_oe_d;
            cs_n    <= cs_n_d;
            ad_n    <= ad_n_d;
            wr_n    <= wr_n_d;
            rd_n    <= rd_n_d;
            ocupado <= (estado_sig != IDLE);
            listo   <= (estado == RECUPERA) && fin_fase;
            if ((estado == DATO_ACT) && fin_fase && lectura_q) begin
                dato_leido <= ad_in;
            end
        end
    end

endmodule

// File: doc/secuenciador_bus_rtc.md
# secuenciador_bus_rtc

Bus sequencer that sits directly downstream of the address register in the RTC interface. It takes the 8-bit register address held there, plus a write datum from the processor port, and runs one complete multiplexed address/data bus cycle to the external RTC chip (write or read). On a read it returns the captured byte to the processor side. All bus strobe timing is generated by a phase counter, so the processor only issues a one-cycle start pulse and waits for `listo`.

## Interface
Parameters:
- `T_FASE`, default 4: clock cycles per bus phase; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `direccion`  in  8  RTC register address, fed from the address register output.
- `dato_escritura`  in  8  byte to write; taken from `port_out`.
- `inicio_escritura`  in  1  one-cycle pulse that starts a write cycle.
- `inicio_lectura`  in  1  one-cycle pulse that starts a read cycle.
- `ad_in`  in  8  bus value returned by the chip.
- `ad_out`  out  8  bus value driven towards the chip.
- `ad_oe`  out  1  output enable for the tri-state bus; 1 = FPGA drives.
- `cs_n`, `ad_n`, `wr_n`, `rd_n`  out  1 each  active-low chip select, address strobe (0 = address phase), write strobe and read strobe.
- `dato_leido`  out  8  last byte read from the chip.
- `ocupado`  out  1  high while a bus cycle is in progress.
- `listo`  out  1  one-cycle pulse when a bus cycle completes.

## Operation
- States: IDLE, DIR_ACT, DIR_FIN, DATO_ACT, DATO_FIN, RECUPERA.
  - Each non-IDLE state lasts exactly `T_FASE` cycles.
  - The phase counter counts 0..`T_FASE`-1 and clears on every state change.
- IDLE:
  - Outputs: all strobes 1, `ad_oe`=0, `ad_out`=0.
  - On a start pulse, `direccion`, `dato_escritura` and the operation type are latched internally, and the block moves to DIR_ACT.
- DIR_ACT:
  - `cs_n`=0, `ad_n`=0, `wr_n`=0, `ad_oe`=1.
  - `ad_out` = latched address.
- DIR_FIN:
  - Same as DIR_ACT except `wr_n`=1, so the address is latched by the chip on this rising edge.
- DATO_ACT:
  - `ad_n`=1 in both operations.
  - Write: `wr_n`=0, `ad_oe`=1, `ad_out` = latched datum.
  - Read: `rd_n`=0, `ad_oe`=0.
  - Read capture: `ad_in` is sampled into `dato_leido` on the clock edge that ends the last DATO_ACT cycle.
- DATO_FIN:
  - Strobes return to 1; `cs_n` stays 0.
  - Write: `ad_oe` stays 1 (hold time). Read: `ad_oe` stays 0.
- RECUPERA:
  - `cs_n`=1, `ad_oe`=0.
  - Then the block returns to IDLE with a `listo` pulse.
- Start pulses while `ocupado`=1 are ignored; they are not queued.
- If `inicio_escritura` and `inicio_lectura` arrive in the same cycle, the write wins and the read is dropped.
- `dato_leido` holds its value until the next read completes; writes do not change it.
- `ad_oe` and `rd_n` are never both active.
- All outputs are registered, so the bus has no glitches.

## Timing
- Reset values: `cs_n`, `ad_n`, `wr_n`, `rd_n` = 1; `ad_oe`=0; `ad_out`=0; `dato_leido`=0; `ocupado`=0; `listo`=0; state = IDLE.
- If a start is sampled at edge N:
  - DIR_ACT outputs are visible after edge N.
  - `ocupado` is 1 for the next 5·`T_FASE` cycles.
- `listo` is high for exactly the one cycle immediately after RECUPERA.
  - In that cycle `ocupado`=0 and a new start is accepted.
- Total latency from start to `listo` is 5·`T_FASE` + 1 cycles; with the default this is 21.
- Reset in the middle of a cycle:
  - On the next edge the state is IDLE and the bus is released (`ad_oe`=0, all strobes 1).
  - No `listo` pulse is generated.
  - `dato_leido` is cleared.

## Structure
- Shared package `rtc_bus_pkg` holds:
  - the state enum,
  - the strobe idle level constant,
  - the default phase length.
- The phase counter is a sub-module, `temporizador_fase`. Its port is width-parameterized and it pulses a terminal-count output.
- The FSM and the output registers stay in the top module.

## Test plan
1. Reset, then idle with no starts: all strobes stay 1, `ad_oe`=0, `ocupado`=0 for 50 cycles.
2. Write with `direccion`=0x21 and `dato_escritura`=0x5A (`T_FASE`=4):
   - `ad_out`=0x21 with `ad_n`=0 for 8 cycles, and `wr_n`=0 for the first 4 of them.
   - Then `ad_out`=0x5A with `wr_n`=0 for 4 cycles.
   - `listo` arrives 21 cycles after the start.
3. Read with `direccion`=0x33, the chip model driving 0xC7 during DATO_ACT:
   - `rd_n`=0 for 4 cycles with `ad_oe`=0.
   - `dato_leido`=0xC7 when `listo` fires.
   - `dato_leido` is unchanged after a later write.
4. Both starts asserted in the same cycle: a write cycle runs (`wr_n` pulses, `rd_n` stays 1). Separately, a start pulse sent in the middle of a cycle is ignored, and exactly one `listo` follows.
5. `rst` asserted in the middle of a write during DATO_ACT:
   - Next cycle: `ad_oe`=0, `cs_n`=1, `ocupado`=0, and there is no `listo`.
   - A following read completes normally.
6. Back-to-back operations: a start in the `listo` cycle is accepted, giving two reads that complete 21 cycles apart. Repeat with `T_FASE`=1, which gives a latency of 6 cycles.
